// File: rtl/uart_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_mult_pkg
// Description : Shared types and sizing helpers for the UART multiplier
//               frame controller. It holds the controller state enum, the
//               default frame header byte and the operand/product width
//               functions.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_mult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX_A     = 3'd1,
        ST_RX_B     = 3'd2,
        ST_MUL_GO   = 3'd3,
        ST_MUL_WAIT = 3'd4,
        ST_TX_LOAD  = 3'd5,
        ST_TX_BUSY  = 3'd6,
        ST_TX_DONE  = 3'd7
    } ctrl_state_t;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned OP_BYTES_DEFAULT  = 2;

    // Operand width in bits for a given operand byte count
    function automatic int unsigned op_width(input int unsigned op_bytes);
        return 8 * op_bytes;
    endfunction

    // Product width in bits for a given operand byte count
    function automatic int unsigned prod_width(input int unsigned op_bytes);
        return 16 * op_bytes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_mult_timeout.sv
`default_nettype none
// ============================================================================
// Module      : uart_mult_timeout
// Description : Inter-byte timeout counter. Counts while enabled, clears on
//               request, and flags expiry once the count reaches LIMIT-1.
// Ports       : clk       - system clock
//               rst_n     - asynchronous active-low reset
//               i_clear   - synchronous clear (highest priority)
//               i_enable  - count enable
//               o_expire  - high while enabled and count == LIMIT-1
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mult_timeout #(
    parameter logic [27:0] LIMIT = 28'd1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    logic [27:0] count_q;
    logic [27:0] count_d;

    assign o_expire = i_enable && (count_q == (LIMIT - 28'd1));

    // Counter holds at the expiry value so the flag cannot wrap away
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && !o_expire) begin
            count_d = count_q + 28'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_mult_ctrl
// Description : Frame controller between a UART rx/tx pair and a multiplier.
//               Parses SYNC_BYTE + A (LE) + B (LE), launches one multiply and
//               streams the product back LSB first.
// Ports       : clk_int, uart_reset_n (async, active-low)
//               rx_data/rx_valid     - received byte stream
//               tx_ready/tx_start/tx_data - transmitter handshake
//               mul_a/mul_b/mul_start, mul_done/mul_result - multiplier
//               busy      - high outside IDLE
//               frame_err - one-cycle pulse on inter-byte timeout
// Options     : UART_MULT_CSUM_EN - appends an XOR checksum byte
//               (SYNC ^ operand bytes ^ product bytes) after the product.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mult_ctrl
    import uart_mult_pkg::*;
#(
    parameter int unsigned OP_BYTES       = OP_BYTES_DEFAULT,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter logic [27:0] TIMEOUT_CYCLES = 28'd1000000
) (
    input  logic                            clk_int,
    input  logic                            uart_reset_n,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    input  logic                            tx_ready,
    output logic                            tx_start,
    output logic [7:0]                      tx_data,
    output logic [op_width(OP_BYTES)-1:0]   mul_a,
    output logic [op_width(OP_BYTES)-1:0]   mul_b,
    output logic                            mul_start,
    input  logic                            mul_done,
    input  logic [prod_width(OP_BYTES)-1:0] mul_result,
    output logic                            busy,
    output logic                            frame_err
);

`ifdef UART_MULT_CSUM_EN
    localparam int unsigned NB_TX = 2 * OP_BYTES + 1;
`else
    localparam int unsigned NB_TX = 2 * OP_BYTES;
`endif
    localparam int CW = $clog2(NB_TX + 1);

    ctrl_state_t                      state_q, state_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [op_width(OP_BYTES)-1:0]    a_q, a_d, b_q, b_d;
    logic [prod_width(OP_BYTES)-1:0]  res_q, res_d;
    logic [7:0]                       tx_data_q, tx_data_d;
    logic                             tx_start_q, tx_start_d;
    logic                             mul_start_q, mul_start_d;
    logic                             frame_err_q, frame_err_d;
    logic                             seen_low_q, seen_low_d;

    logic                             w_to_enable;
    logic                             w_to_clear;
    logic                             w_to_expire;
    logic [7:0]                       w_tx_byte;

    assign w_to_enable = (state_q == ST_RX_A) || (state_q == ST_RX_B);
    assign w_to_clear  = rx_valid || !w_to_enable;

    uart_mult_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk_int),
        .rst_n    (uart_reset_n),
        .i_clear  (w_to_clear),
        .i_enable (w_to_enable),
        .o_expire (w_to_expire)
    );

`ifdef UART_MULT_CSUM_EN
    logic [7:0] w_csum;
    always_comb begin
        w_csum = SYNC_BYTE;
        for (int i = 0; i < int'(OP_BYTES); i++) begin
            w_csum = w_csum ^ a_q[8*i +: 8] ^ b_q[8*i +: 8];
        end
        for (int i = 0; i < int'(2 * OP_BYTES); i++) begin
            w_csum = w_csum ^ res_q[8*i +: 8];
        end
    end
`endif

    // Byte selected for transmission by the shared byte counter
    always_comb begin
        w_tx_byte = '0;
        for (int i = 0; i < int'(2 * OP_BYTES); i++) begin
            if (cnt_q == CW'(i)) begin
                w_tx_byte = res_q[8*i +: 8];
            end
        end
`ifdef UART_MULT_CSUM_EN
        if (cnt_q == CW'(2 * OP_BYTES)) begin
            w_tx_byte = w_csum;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        tx_data_d   = tx_data_q;
        seen_low_d  = seen_low_q;
        tx_start_d  = 1'b0;
        mul_start_d = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_RX_A;
                    cnt_d   = '0;
                end
            end
            ST_RX_A, ST_RX_B: begin
                // A byte arriving on the expiry cycle takes priority
                if (rx_valid) begin
                    for (int i = 0; i < int'(OP_BYTES); i++) begin
                        if (cnt_q == CW'(i)) begin
                            if (state_q == ST_RX_A) a_d[8*i +: 8] = rx_data;
                            else                    b_d[8*i +: 8] = rx_data;
                        end
                    end
                    if (cnt_q == CW'(OP_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = (state_q == ST_RX_A) ? ST_RX_B : ST_MUL_GO;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (w_to_expire) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
            end
            ST_MUL_GO: begin
                mul_start_d = 1'b1;
                state_d     = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                if (mul_done) begin
                    res_d   = mul_result;
                    cnt_d   = '0;
                    state_d = ST_TX_LOAD;
                end
            end
            ST_TX_LOAD: begin
                if (tx_ready) begin
                    tx_data_d  = w_tx_byte;
                    tx_start_d = 1'b1;
                    seen_low_d = 1'b0;
                    state_d    = ST_TX_BUSY;
                end
            end
            ST_TX_BUSY: begin
                // Wait for the transmitter to drop ready (byte accepted),
                // then for it to come back (byte finished).
                if (!seen_low_q) begin
                    if (!tx_ready) seen_low_d = 1'b1;
                end else if (tx_ready) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q == CW'(NB_TX - 1)) ? ST_TX_DONE : ST_TX_LOAD;
                end
            end
            ST_TX_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_int or negedge uart_reset_n) begin
        if (!uart_reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            mul_start_q <= 1'b0;
            frame_err_q <= 1'b0;
            seen_low_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            mul_start_q <= mul_start_d;
            frame_err_q <= frame_err_d;
            seen_low_q  <= seen_low_d;
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign mul_start = mul_start_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mult_ctrl
// Description : Self-checking bench for uart_mult_ctrl with a UART
//               transmitter model, a multiplier model and a frame-level
//               reference (product bytes LSB first, optional XOR checksum).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mult_ctrl;

    localparam int OPB  = 2;
    localparam int TOUT = 100;
`ifdef UART_MULT_CSUM_EN
    localparam int NB = 2 * OPB + 1;
`else
    localparam int NB = 2 * OPB;
`endif

    logic              clk_int      = 1'b0;
    logic              uart_reset_n = 1'b0;
    logic [7:0]        rx_data      = 8'h00;
    logic              rx_valid     = 1'b0;
    logic              tx_ready     = 1'b1;
    logic              mul_done     = 1'b0;
    logic [16*OPB-1:0] mul_result   = '0;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [8*OPB-1:0]  mul_a;
    logic [8*OPB-1:0]  mul_b;
    logic              mul_start;
    logic              busy;
    logic              frame_err;

    uart_mult_ctrl #(
        .OP_BYTES       (OPB),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (28'd100)
    ) dut (
        .clk_int      (clk_int),
        .uart_reset_n (uart_reset_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_ready     (tx_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_start    (mul_start),
        .mul_done     (mul_done),
        .mul_result   (mul_result),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    always #5 clk_int = ~clk_int;

    int cyc = 0;
    always @(posedge clk_int) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Shared between stimulus (writer) and models (readers)
    logic [15:0] exp_a = '0;
    logic [15:0] exp_b = '0;
    int          last_rx_cyc = 0;
    int          stall_extra = 0;

    // Model state, written only by the model process below
    int          n_mul_start = 0;
    int          n_frame_err = 0;
    int          hold_left   = 0;
    int          mul_wait    = 0;
    int          last_done_cyc = 0;
    bit          in_flight   = 0;
    bit          first_tx_pending = 0;
    logic [7:0]  held_byte   = 8'h00;
    logic [7:0]  byte_q[$];

    // Multiplier and UART transmitter models
    always @(negedge clk_int) begin
        if (!uart_reset_n) begin
            tx_ready         = 1'b1;
            hold_left        = 0;
            in_flight        = 0;
            mul_wait         = 0;
            mul_done         = 1'b0;
            first_tx_pending = 0;
        end else begin
            mul_done = 1'b0;
            if (frame_err) n_frame_err++;
            if (mul_start) begin
                n_mul_start++;
                check_val("mul_a", mul_a, exp_a);
                check_val("mul_b", mul_b, exp_b);
                check_val("mul_start_latency", cyc - last_rx_cyc, 2);
                mul_wait = $urandom_range(1, 5);
            end else if (mul_wait > 0) begin
                mul_wait--;
                if (mul_wait == 0) begin
                    mul_done         = 1'b1;
                    mul_result       = 32'(exp_a) * 32'(exp_b);
                    last_done_cyc    = cyc;
                    first_tx_pending = 1;
                    if (stall_extra > 0) begin
                        tx_ready  = 1'b0;
                        hold_left = stall_extra;
                    end
                end
            end
            if (tx_start) begin
                check_val("tx_start_while_ready", tx_ready, 1);
                if (first_tx_pending && stall_extra == 0)
                    check_val("tx_first_latency", cyc - last_done_cyc, 2);
                first_tx_pending = 0;
                byte_q.push_back(tx_data);
                held_byte = tx_data;
                in_flight = 1;
                tx_ready  = 1'b0;
                hold_left = 3 + stall_extra;
            end else if (hold_left > 0) begin
                if (in_flight) check_val("tx_data_stable", tx_data, held_byte);
                hold_left--;
                if (hold_left == 0) begin
                    tx_ready  = 1'b1;
                    in_flight = 0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_int);
    endtask

    // Strobe one byte; consecutive calls are 2 cycles apart, idle(g-2)
    // between calls gives a gap of g cycles.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_int);
        rx_valid    = 1'b1;
        rx_data     = b;
        last_rx_cyc = cyc;
        @(negedge clk_int);
        rx_valid    = 1'b0;
        rx_data     = 8'($urandom);
    endtask

    task automatic run_frame(input logic [15:0] a, input logic [15:0] b,
                             input int njunk, input int gap_at, input int gap_len);
        logic [7:0]  pay[4];
        logic [31:0] p;
        logic [7:0]  csum;
        logic [7:0]  j;
        int base, ms0, fe0, t;
        base = byte_q.size();
        ms0  = n_mul_start;
        fe0  = n_frame_err;
        exp_a = a;
        exp_b = b;
        p = 32'(a) * 32'(b);
        pay[0] = a[7:0]; pay[1] = a[15:8]; pay[2] = b[7:0]; pay[3] = b[15:8];
        for (int i = 0; i < njunk; i++) begin
            j = 8'($urandom);
            if (j == 8'hA5) j = 8'h5A;
            send_byte(j);
            idle($urandom_range(0, 3));
        end
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) begin
            if (i == gap_at) idle(gap_len - 2);
            else             idle($urandom_range(0, 4));
            send_byte(pay[i]);
        end
        t = 0;
        while (((byte_q.size() - base) < NB || busy) && t < 5000) begin
            @(negedge clk_int);
            t++;
        end
        check_val("frame_complete", t < 5000, 1);
        idle(20);
        check_val("tx_count", byte_q.size() - base, NB);
        csum = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            check_val("tx_byte", byte_q[base + i], p[8*i +: 8]);
            csum = csum ^ pay[i] ^ p[8*i +: 8];
        end
`ifdef UART_MULT_CSUM_EN
        check_val("tx_csum", byte_q[base + 4], csum);
`endif
        check_val("mul_start_count", n_mul_start - ms0, 1);
        check_val("frame_err_none", n_frame_err - fe0, 0);
        check_val("busy_after", busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0, ms0, base, t;

        // Reset state
        idle(2);
        check_val("rst_tx_start", tx_start, 0);
        check_val("rst_tx_data", tx_data, 0);
        check_val("rst_mul_a", mul_a, 0);
        check_val("rst_mul_b", mul_b, 0);
        check_val("rst_mul_start", mul_start, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_frame_err", frame_err, 0);
        @(negedge clk_int);
        uart_reset_n = 1'b1;
        idle(3);

        // Directed frames
        run_frame(16'h0003, 16'h0005, 0, -1, 0);
        run_frame(16'hFFFF, 16'hFFFF, 2, -1, 0);
        run_frame(16'hA5A5, 16'h01A5, 0, -1, 0);
        run_frame(16'h0002, 16'h0003, 0, -1, 0);

        // Timeout abort after a partial operand
        fe0 = n_frame_err; ms0 = n_mul_start;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        idle(150);
        check_val("timeout_err", n_frame_err - fe0, 1);
        check_val("timeout_busy", busy, 0);
        check_val("timeout_no_mul", n_mul_start - ms0, 0);
        run_frame(16'h1357, 16'h2468, 0, -1, 0);

        // Gap just beyond the limit aborts; gap exactly at the limit does not
        fe0 = n_frame_err;
        send_byte(8'hA5); send_byte(8'h01);
        idle(TOUT + 1 - 2);
        send_byte(8'h00);
        idle(5);
        check_val("gap_over_err", n_frame_err - fe0, 1);
        check_val("gap_over_busy", busy, 0);
        run_frame(16'h00FF, 16'h0101, 0, 2, TOUT);

        // Slow transmitter
        stall_extra = 50;
        run_frame(16'hBEEF, 16'h1234, 0, -1, 0);
        stall_extra = 0;

        // Reset while the second product byte is in flight
        base = byte_q.size();
        exp_a = 16'h1234; exp_b = 16'h0042;
        send_byte(8'hA5); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h42); send_byte(8'h00);
        t = 0;
        while ((byte_q.size() - base) < 2 && t < 3000) begin
            @(negedge clk_int);
            t++;
        end
        check_val("rst_reach_byte2", t < 3000, 1);
        @(negedge clk_int);
        uart_reset_n = 1'b0;
        #1;
        check_val("midrst_tx_start", tx_start, 0);
        check_val("midrst_mul_start", mul_start, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_tx_data", tx_data, 0);
        check_val("midrst_mul_a", mul_a, 0);
        idle(3);
        @(negedge clk_int);
        uart_reset_n = 1'b1;
        idle(2);
        run_frame(16'h0777, 16'h0009, 1, -1, 0);

        // Randomized frames, payload occasionally containing the sync value
        for (int k = 0; k < 8; k++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra[7:0] = 8'hA5;
            if ($urandom_range(0, 3) == 0) rb[15:8] = 8'hA5;
            run_frame(ra, rb, $urandom_range(0, 3), -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
